// File: rtl/qpsk_mod_gen.sv
// QPSK modulator: packs a handshaked serial bit stream into dibits, holds each
// symbol for SPS carrier samples and forms seq = (+/-cos +/-sine)/2.
// The carrier ROM address is the sample counter, so carrier and symbols stay phase-locked.
// Optional feature: define QPSK_DIFF_EN for differential (DQPSK) symbol encoding.
module qpsk_mod_gen #(
    parameter int unsigned SPS   = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk_20,
    input  logic                    rst,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic        [CNT_W-1:0] car_addr,
    input  logic signed [7:0]       sine,
    input  logic signed [7:0]       cos,
    output logic signed [7:0]       seq,
    output logic                    sym_start,
    output logic                    underrun
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SPS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              half_q, half_d;
    logic              half_v_q, half_v_d;
    logic [1:0]        pend_q, pend_d;     // {q, i}
    logic              pend_v_q, pend_v_d;
    logic [1:0]        sym_q, sym_d;       // {Q, I}
    logic              active_q, active_d;
    logic signed [7:0] seq_q, seq_d;
    logic              sym_start_q, sym_start_d;
    logic              underrun_q, underrun_d;
`ifdef QPSK_DIFF_EN
    logic [1:0]        phase_q, phase_d;
`endif

    logic              boundary;
    logic              accept;
    logic              load;
    logic signed [7:0] c_sel;
    logic signed [7:0] s_sel;
    logic signed [8:0] sum;

    // Negation with -128 saturating to +127 so the result stays in 8 bits.
    function automatic logic signed [7:0] neg_sat(input logic signed [7:0] x);
        return (x == 8'sh80) ? 8'sh7f : -x;
    endfunction

`ifdef QPSK_DIFF_EN
    // Gray-ordered phase increment selected by the incoming dibit {q, i}.
    function automatic logic [1:0] dibit_inc(input logic [1:0] d);
        logic [1:0] r;
        unique case (d)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b11:   r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Absolute phase to constellation point {Q, I}.
    function automatic logic [1:0] phase_sym(input logic [1:0] p);
        logic [1:0] r;
        unique case (p)
            2'd0:    r = 2'b11;
            2'd1:    r = 2'b10;
            2'd2:    r = 2'b00;
            default: r = 2'b01;
        endcase
        return r;
    endfunction
`endif

    assign boundary = (cnt_q == CntLast);
    assign accept   = bit_valid & ~pend_v_q;
    // A dibit completed on this same edge lands in pend and only counts for the next boundary.
    assign load     = boundary & pend_v_q;

    // Next-state logic: dibit assembly, sample counter, FSM and symbol load/underrun.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        half_v_d   = half_v_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        sym_d      = sym_q;
        active_d   = active_q;
        underrun_d = 1'b0;
`ifdef QPSK_DIFF_EN
        phase_d    = phase_q;
`endif

        if (accept) begin
            if (half_v_q) begin
                pend_d   = {half_q, bit_in};
                pend_v_d = 1'b1;
                half_v_d = 1'b0;
            end else begin
                half_d   = bit_in;
                half_v_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = CntLast;
                if (load) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            pend_v_d = 1'b0;
            active_d = 1'b1;
`ifdef QPSK_DIFF_EN
            phase_d  = phase_q + dibit_inc(pend_q);
            sym_d    = phase_sym(phase_d);
`else
            sym_d    = pend_q;
`endif
        end else if (boundary && (state_q == StRun)) begin
            // Nothing to send: keep the counter running, transmit a zero symbol.
            active_d   = 1'b0;
            underrun_d = 1'b1;
        end
    end

    // Datapath: sign-select the carrier branches and halve their sum.
    always_comb begin
        c_sel       = sym_q[0] ? cos  : neg_sat(cos);
        s_sel       = sym_q[1] ? sine : neg_sat(sine);
        sum         = {c_sel[7], c_sel} + {s_sel[7], s_sel};
        seq_d       = active_q ? 8'(sum >>> 1) : 8'sd0;
        sym_start_d = (cnt_q == '0) && active_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_20) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= CntLast;
            half_q      <= 1'b0;
            half_v_q    <= 1'b0;
            pend_q      <= 2'b00;
            pend_v_q    <= 1'b0;
            sym_q       <= 2'b00;
            active_q    <= 1'b0;
            seq_q       <= 8'sd0;
            sym_start_q <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef QPSK_DIFF_EN
            phase_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            half_v_q    <= half_v_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            sym_q       <= sym_d;
            active_q    <= active_d;
            seq_q       <= seq_d;
            sym_start_q <= sym_start_d;
            underrun_q  <= underrun_d;
`ifdef QPSK_DIFF_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign bit_ready = ~pend_v_q;
    assign car_addr  = cnt_q;
    assign seq       = seq_q;
    assign sym_start = sym_start_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_qpsk_mod_gen.sv
// Self-checking bench for qpsk_mod_gen: scoreboard of queued symbols checked sample by sample.
module tb_qpsk_mod_gen;

    localparam int SPS   = 10;
    localparam int CNT_W = 8;

    logic                   clk_20 = 1'b0;
    logic                   rst;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   bit_ready;
    logic       [CNT_W-1:0] car_addr;
    logic signed [7:0]      sine;
    logic signed [7:0]      cos;
    logic signed [7:0]      seq;
    logic                   sym_start;
    logic                   underrun;

    logic                   use_tab;
    logic signed [7:0]      cst_cos;
    logic signed [7:0]      cst_sin;

    typedef struct packed {
        logic qq;
        logic ii;
    } sym_t;

    sym_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tb_phase = 0;

    always #5 clk_20 = ~clk_20;

    qpsk_mod_gen #(
        .SPS   (SPS),
        .CNT_W (CNT_W)
    ) dut (
        .clk_20    (clk_20),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .car_addr  (car_addr),
        .sine      (sine),
        .cos       (cos),
        .seq       (seq),
        .sym_start (sym_start),
        .underrun  (underrun)
    );

    function automatic logic signed [7:0] tab_c(input int a);
        return 8'(a * 29 - 128);
    endfunction

    function automatic logic signed [7:0] tab_s(input int a);
        return 8'(90 - a * 37);
    endfunction

    // Combinational carrier ROM model.
    always_comb begin
        cos  = use_tab ? tab_c(int'(car_addr)) : cst_cos;
        sine = use_tab ? tab_s(int'(car_addr)) : cst_sin;
    end

    function automatic int rom_c(input int a);
        return use_tab ? int'(tab_c(a)) : int'(cst_cos);
    endfunction

    function automatic int rom_s(input int a);
        return use_tab ? int'(tab_s(a)) : int'(cst_sin);
    endfunction

    // Reference sample: floor((+/-c +/-s)/2) with saturating negation.
    function automatic int exp_seq(input logic qq, input logic ii, input int c, input int s);
        int cc;
        int ss;
        int sum;
        cc  = ii ? c : ((c == -128) ? 127 : -c);
        ss  = qq ? s : ((s == -128) ? 127 : -s);
        sum = cc + ss;
        if (sum < 0) return -((-sum + 1) / 2);
        return sum / 2;
    endfunction

    task automatic push_dibit(input logic q, input logic i);
        sym_t e;
`ifdef QPSK_DIFF_EN
        int inc;
        case ({q, i})
            2'b00:   inc = 0;
            2'b01:   inc = 1;
            2'b11:   inc = 2;
            default: inc = 3;
        endcase
        tb_phase = (tb_phase + inc) % 4;
        case (tb_phase)
            0:       e = '{qq: 1'b1, ii: 1'b1};
            1:       e = '{qq: 1'b1, ii: 1'b0};
            2:       e = '{qq: 1'b0, ii: 1'b0};
            default: e = '{qq: 1'b0, ii: 1'b1};
        endcase
`else
        e = '{qq: q, ii: i};
`endif
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_20);
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        @(negedge clk_20);
        @(negedge clk_20);
        rst = 1'b0;
        exp_q.delete();
        tb_phase = 0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_bit(input logic b, output bit ok);
        int   t;
        logic r;
        ok        = 1'b0;
        t         = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (t < 8 * SPS) begin
            r = bit_ready;
            @(negedge clk_20);
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_dibit(input logic q, input logic i);
        bit ok1;
        bit ok2;
        send_bit(q, ok1);
        send_bit(i, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL send_dibit: accepted=%b%b required=11", ok1, ok2);
        end else begin
            push_dibit(q, i);
        end
    endtask

    // Waits for each symbol start, pops the scoreboard and checks all SPS samples.
    task automatic check_syms(input int n, input bit last_ur, input string tag);
        int   t;
        int   ev;
        logic ur_exp;
        sym_t e;
        for (int s = 0; s < n; s++) begin
            t = 0;
            while (sym_start !== 1'b1 && t < 4 * SPS) begin
                @(negedge clk_20);
                t++;
            end
            checks++;
            if (sym_start !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s sym%0d start: sym_start=%b queued=%0d required 1 with a queued symbol",
                         tag, s, sym_start, exp_q.size());
                return;
            end
            e = exp_q.pop_front();
            for (int k = 0; k < SPS; k++) begin
                ev     = exp_seq(e.qq, e.ii, rom_c(k), rom_s(k));
                ur_exp = (k == SPS - 1 && s == n - 1) ? last_ur : 1'b0;
                checks++;
                if (int'(seq) !== ev) begin
                    failures++;
                    $display("FAIL %s sym%0d seq[%0d]: got %0d required %0d", tag, s, k, seq, ev);
                end
                checks++;
                if (sym_start !== (k == 0)) begin
                    failures++;
                    $display("FAIL %s sym%0d sym_start[%0d]: got %b required %b", tag, s, k,
                             sym_start, (k == 0));
                end
                checks++;
                if (int'(car_addr) !== (k + 1) % SPS) begin
                    failures++;
                    $display("FAIL %s sym%0d car_addr[%0d]: got %0d required %0d", tag, s, k,
                             car_addr, (k + 1) % SPS);
                end
                checks++;
                if (underrun !== ur_exp) begin
                    failures++;
                    $display("FAIL %s sym%0d underrun[%0d]: got %b required %b", tag, s, k,
                             underrun, ur_exp);
                end
                if (k < SPS - 1) @(negedge clk_20);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (seq !== 8'sd0 || sym_start !== 1'b0 || underrun !== 1'b0) begin
                failures++;
                $display("FAIL reset outputs c%0d: seq=%0d sym_start=%b underrun=%b required 0 0 0",
                         c, seq, sym_start, underrun);
            end
            checks++;
            if (bit_ready !== 1'b1 || int'(car_addr) !== SPS - 1) begin
                failures++;
                $display("FAIL reset idle c%0d: bit_ready=%b car_addr=%0d required 1 %0d",
                         c, bit_ready, car_addr, SPS - 1);
            end
            @(negedge clk_20);
        end
    endtask

    task automatic test_basic();
        do_reset();
        use_tab = 1'b0;
        cst_cos = 8'sd100;
        cst_sin = 8'sd0;
        fork
            send_dibit(1'b1, 1'b1);
            check_syms(1, 1'b1, "t1_basic");
        join
    endtask

    task automatic test_saturation();
        do_reset();
        use_tab = 1'b0;
        cst_cos = -8'sd128;
        cst_sin = -8'sd128;
        fork
            begin
                send_dibit(1'b0, 1'b0);
                send_dibit(1'b1, 1'b1);
            end
            check_syms(2, 1'b1, "t2_sat");
        join
    endtask

    task automatic test_back_to_back();
        do_reset();
        use_tab = 1'b1;
        fork
            begin
                send_dibit(1'b1, 1'b0);
                send_dibit(1'b0, 1'b1);
                checks++;
                if (bit_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL t3 bit_ready with pend full: got %b required 0", bit_ready);
                end
                send_dibit(1'b1, 1'b1);
                send_dibit(1'b0, 1'b0);
            end
            check_syms(4, 1'b1, "t3_b2b");
        join
    endtask

    task automatic test_underrun();
        do_reset();
        use_tab = 1'b1;
        fork
            begin
                int t;
                send_dibit(1'b0, 1'b1);
                send_dibit(1'b1, 1'b1);
                t = 0;
                while (underrun !== 1'b1 && t < 6 * SPS) begin
                    @(negedge clk_20);
                    t++;
                end
                send_dibit(1'b1, 1'b0);
            end
            begin
                check_syms(2, 1'b1, "t4_pre");
                for (int k = 0; k < SPS; k++) begin
                    @(negedge clk_20);
                    checks++;
                    if (seq !== 8'sd0 || sym_start !== 1'b0 || underrun !== 1'b0) begin
                        failures++;
                        $display("FAIL t4 zero symbol[%0d]: seq=%0d sym_start=%b underrun=%b required 0 0 0",
                                 k, seq, sym_start, underrun);
                    end
                    checks++;
                    if (int'(car_addr) !== (k + 1) % SPS) begin
                        failures++;
                        $display("FAIL t4 car_addr[%0d]: got %0d required %0d", k, car_addr,
                                 (k + 1) % SPS);
                    end
                end
                check_syms(1, 1'b1, "t4_post");
            end
        join
    endtask

    task automatic test_reset_mid();
        int t;
        int ev;
        bit ok;
        do_reset();
        use_tab = 1'b0;
        cst_cos = 8'sd100;
        cst_sin = 8'sd50;
        send_dibit(1'b1, 1'b1);
        t = 0;
        while (sym_start !== 1'b1 && t < 4 * SPS) begin
            @(negedge clk_20);
            t++;
        end
        repeat (3) @(negedge clk_20);
        ev = (exp_q.size() > 0) ? exp_seq(exp_q[0].qq, exp_q[0].ii, 100, 50) : 999;
        checks++;
        if (int'(seq) !== ev) begin
            failures++;
            $display("FAIL t5 seq before reset: got %0d required %0d", seq, ev);
        end
        send_bit(1'b1, ok);
        rst = 1'b1;
        @(negedge clk_20);
        checks++;
        if (seq !== 8'sd0 || bit_ready !== 1'b1 || int'(car_addr) !== SPS - 1) begin
            failures++;
            $display("FAIL t5 after reset: seq=%0d bit_ready=%b car_addr=%0d required 0 1 %0d",
                     seq, bit_ready, car_addr, SPS - 1);
        end
        rst = 1'b0;
        exp_q.delete();
        tb_phase = 0;
        fork
            send_dibit(1'b0, 1'b1);
            check_syms(1, 1'b1, "t5_after");
        join
    endtask

`ifdef QPSK_DIFF_EN
    task automatic test_diff();
        do_reset();
        use_tab = 1'b0;
        cst_cos = 8'sd100;
        cst_sin = 8'sd40;
        fork
            repeat (4) send_dibit(1'b0, 1'b1);
            check_syms(4, 1'b1, "t6_diff");
        join
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        use_tab   = 1'b0;
        cst_cos   = 8'sd0;
        cst_sin   = 8'sd0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
`ifdef QPSK_DIFF_EN
        test_diff();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
